// File: rtl/snax_gemm_wb_pkg.sv
// Shared types and sizing helpers for the GEMM write-back stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package snax_gemm_wb_pkg;

  // Sequencer states: waiting for a tile, streaming beats, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_e;

  // Number of write beats needed to drain one result tile.
  function automatic int unsigned wb_beats(input int unsigned result_width,
                                           input int unsigned num_ports,
                                           input int unsigned data_width);
    return result_width / (num_ports * data_width);
  endfunction

  // Bytes per TCDM word.
  function automatic int unsigned wb_word_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int unsigned wb_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snax_gemm_wb_port_tracker.sv
// Per-port accept tracker: remembers whether this port's word of the current beat was taken.
// Latency: accept flag sets on the edge where valid & ready; valid drops the following cycle.
// Backpressure: holds valid high while ready is low; ready while valid is low is ignored.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear        : drop the accepted flag (new beat / new tile)
//   valid        : beat is active for this port
//   ready        : TCDM accepted the request this cycle
//   accepted     : word of the current beat has already been taken
//   port_valid   : request valid towards TCDM (registered state only)
module snax_gemm_wb_port_tracker (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic valid,
  input  logic ready,
  output logic accepted,
  output logic port_valid
);

  logic accepted_q;

  // Clear wins over a same-cycle handshake: the completing beat's handshake
  // is already accounted for by the beat-complete logic in the top level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      accepted_q <= 1'b0;
    end else if (clear) begin
      accepted_q <= 1'b0;
    end else if (port_valid && ready) begin
      accepted_q <= 1'b1;
    end
  end

  assign port_valid = valid & ~accepted_q;
  assign accepted   = accepted_q;

endmodule

// File: rtl/snax_gemm_writeback.sv
// GEMM result write-back: takes one result tile and streams it to TCDM as multi-port write beats.
// Latency: accept at cycle 0, beat b valid in cycle 1+b, done_o in cycle Beats+1 without stalls.
// Backpressure: per-port q_ready stalls only the current beat; accepted ports idle until next beat.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   result_valid_i/ready_o  : tile handshake; result_i holds word k at [k*DataWidth +: DataWidth]
//   base_addr_i             : destination byte address, word-aligned on capture
//   tcdm_q_*                : NumPorts parallel write request channels
//   busy_o                  : a tile is held (WRITE or DONE)
//   done_o                  : one-cycle pulse after the last word is accepted
module snax_gemm_writeback
  import snax_gemm_wb_pkg::*;
#(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned NumPorts    = 8,
  parameter int unsigned ResultWidth = 2048,
  parameter int unsigned AddrWidth   = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              result_valid_i,
  output logic                              result_ready_o,
  input  logic [ResultWidth-1:0]            result_i,
  input  logic [AddrWidth-1:0]              base_addr_i,
  output logic [NumPorts-1:0]               tcdm_q_valid_o,
  input  logic [NumPorts-1:0]               tcdm_q_ready_i,
  output logic [NumPorts*AddrWidth-1:0]     tcdm_q_addr_o,
  output logic [NumPorts*DataWidth-1:0]     tcdm_q_data_o,
  output logic [NumPorts*DataWidth/8-1:0]   tcdm_q_strb_o,
  output logic [NumPorts-1:0]               tcdm_q_write_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int unsigned Beats     = wb_beats(ResultWidth, NumPorts, DataWidth);
  localparam int unsigned WordBytes = wb_word_bytes(DataWidth);
  localparam int unsigned BeatW     = wb_cnt_width(Beats);
  localparam int unsigned BeatBits  = NumPorts * DataWidth;
  localparam int unsigned StrbWidth = DataWidth / 8;

  if ((ResultWidth % (NumPorts * DataWidth)) != 0 || ResultWidth < NumPorts * DataWidth) begin : g_param_check
    $error("snax_gemm_writeback: ResultWidth must be a non-zero multiple of NumPorts*DataWidth");
  end

  wb_state_e                    state_q, state_d;
  logic [BeatW-1:0]             beat_q;
  logic [Beats-1:0][BeatBits-1:0] tile_q;
  logic [AddrWidth-1:0]         base_q;

  logic [NumPorts-1:0] accepted;
  logic [NumPorts-1:0] port_valid;
  logic [NumPorts-1:0] fire;
  logic [NumPorts-1:0] done_mask;
  logic                in_write;
  logic                tile_accept;
  logic                last_beat;
  logic                beat_done;
  logic                mask_clear;

  assign in_write    = (state_q == WRITE);
  assign tile_accept = (state_q == IDLE) && result_valid_i;
  assign fire        = port_valid & tcdm_q_ready_i;
  // A same-cycle handshake counts towards completing the beat.
  assign done_mask   = accepted | fire;
  assign last_beat   = (beat_q == BeatW'(Beats - 1));
  assign beat_done   = in_write && (&done_mask);
  assign mask_clear  = beat_done || tile_accept;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (tile_accept) begin
        beat_q <= '0;
      end else if (beat_done && !last_beat) begin
        beat_q <= beat_q + BeatW'(1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    result_ready_o = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        result_ready_o = 1'b1;
        if (result_valid_i) state_d = WRITE;
      end
      WRITE: begin
        busy_o = 1'b1;
        if (beat_done && last_beat) state_d = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tile and base are only meaningful while busy, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (tile_accept) begin
      tile_q <= result_i;
      base_q <= base_addr_i & ~AddrWidth'(WordBytes - 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port request generation
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [AddrWidth-1:0] word_idx;
    logic [AddrWidth-1:0] word_addr;

    snax_gemm_wb_port_tracker i_tracker (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (mask_clear),
      .valid      (in_write),
      .ready      (tcdm_q_ready_i[p]),
      .accepted   (accepted[p]),
      .port_valid (port_valid[p])
    );

    // Word k = beat*NumPorts + p; arithmetic wraps at AddrWidth bits.
    assign word_idx  = AddrWidth'(beat_q) * AddrWidth'(NumPorts) + AddrWidth'(p);
    assign word_addr = base_q + word_idx * AddrWidth'(WordBytes);

    // Address/data follow registered state only, so they stay put while stalled.
    assign tcdm_q_addr_o[p*AddrWidth +: AddrWidth] = port_valid[p] ? word_addr : '0;
    assign tcdm_q_data_o[p*DataWidth +: DataWidth] =
      port_valid[p] ? tile_q[beat_q][p*DataWidth +: DataWidth] : '0;
    assign tcdm_q_strb_o[p*StrbWidth +: StrbWidth] = {StrbWidth{port_valid[p]}};
  end

  assign tcdm_q_valid_o = port_valid;
  assign tcdm_q_write_o = port_valid;

endmodule

// File: doc/snax_gemm_writeback.md
# snax_gemm_writeback

Downstream write-back stage for the GEMM accelerator: accepts one complete result tile (default 2048 bits) over a valid/ready handshake and streams it into TCDM as a sequence of multi-port write beats, honouring per-port `q_ready` backpressure. It sits between the GEMM core's result output and the TCDM request ports. It replaces fixed-cycle write-out with a handshaked, backpressure-safe sequencer, and signals completion to the CSR/status logic.

## Interface
- `DataWidth`, 64, bits per TCDM word.
- `NumPorts`, 8, TCDM write ports driven in parallel.
- `ResultWidth`, 2048, bits per result tile; must be a multiple of `NumPorts*DataWidth`.
- `AddrWidth`, 32, TCDM byte-address width.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `result_valid_i` in 1: result tile valid.
- `result_ready_o` out 1: block can accept a tile.
- `result_i` in ResultWidth: result tile; word k = `result_i[k*DataWidth +: DataWidth]`.
- `base_addr_i` in AddrWidth: destination byte address, sampled with the tile.
- `tcdm_q_valid_o` out NumPorts: per-port request valid.
- `tcdm_q_ready_i` in NumPorts: per-port request accepted.
- `tcdm_q_addr_o` out NumPorts*AddrWidth: per-port byte address.
- `tcdm_q_data_o` out NumPorts*DataWidth: per-port write data.
- `tcdm_q_strb_o` out NumPorts*DataWidth/8: all ones while valid, else zero.
- `tcdm_q_write_o` out NumPorts: 1 while valid, else 0.
- `busy_o` out 1: tile held (state is WRITE or DONE).
- `done_o` out 1: one-cycle pulse after the last word is accepted.

## Operation
- Beats = ResultWidth/(NumPorts*DataWidth); default 4. Beat counter width = clog2(Beats), minimum 1.
- States: IDLE, WRITE, DONE.
- IDLE:
  - `result_ready_o`=1.
  - On `result_valid_i`: register the tile and base address, clearing the low clog2(DataWidth/8) address bits; set beat=0 and accepted mask=0; go to WRITE.
- WRITE:
  - Port p drives word k = beat*NumPorts+p at address base + k*(DataWidth/8). Address arithmetic wraps modulo 2^AddrWidth.
  - `tcdm_q_valid_o[p]` = ~accepted[p].
  - On `valid[p] & ready[p]`: set accepted[p]. The port then drops valid and keeps it low until the next beat.
  - Beat completes when `accepted | (valid & ready)` is all ones.
    - If not the last beat: beat+1 and clear the mask in the same edge.
    - If the last beat: go to DONE.
  - Address and data of a port are stable while its valid is high and ready is low.
- DONE:
  - `done_o`=1 for exactly one cycle; no TCDM valids.
  - Next state is IDLE.
- `result_ready_o`=0 in WRITE and DONE. A tile offered during those states waits and is not lost.
- Parameter violations (ResultWidth not a multiple of `NumPorts*DataWidth`) are rejected by an elaboration-time assertion.

## Timing
- Reset: state is IDLE and the mask and beat are cleared.
  - Outputs after reset: `result_ready_o`=1; all `tcdm_q_*` outputs 0; `busy_o`=0; `done_o`=0.
- Accepting a tile takes one cycle (handshake at edge 0). The first beat's requests are valid in cycle 1.
- With no backpressure, beat b is presented in cycle 1+b, `done_o` is high in cycle Beats+1, and `result_ready_o` returns in cycle Beats+2. Default: done at cycle 5, next accept at cycle 6.
- Backpressure stalls only the current beat. Ports that have already accepted stay idle, and no word is ever re-issued.
- Ready arriving in the same cycle as valid counts as acceptance in that cycle.
- `tcdm_q_ready_i` asserted while the port's valid is low is ignored.
- Reset mid-operation (WRITE or DONE): returns to IDLE on the next edge and drops all valids. Writes already accepted are not rolled back, and no `done_o` is produced.
- No combinational path from `tcdm_q_ready_i` to `tcdm_q_valid_o`; valid depends only on registered state.

## Structure
- Package `snax_gemm_wb_pkg` holds:
  - the state enum (IDLE, WRITE, DONE);
  - the Beats/word-byte localparam helper functions.
- Per-port accept tracking is a natural sub-module, `snax_gemm_wb_port_tracker`, instantiated NumPorts times:
  - inputs: clear, valid, ready;
  - outputs: accepted, port valid.
- The top level holds the FSM, beat counter, tile register and address generation.

## Test plan
1. Reset, then tile words k = k+1 with base 0x1000 and all ready=1:
   - beats in cycles 1–4; port p in beat b writes address 0x1000+8*(8b+p) with data 8b+p+1;
   - `done_o` in cycle 5 only.
2. Port 3 ready held low for 3 cycles during beat 0:
   - the other ports are accepted once and then drop valid;
   - port 3 addr/data are stable throughout;
   - beat 1 starts the cycle after port 3 is accepted; `done_o` is delayed by 3 cycles.
3. `result_valid_i` held high through the whole transfer:
   - `result_ready_o`=0 until cycle 6;
   - the second tile is accepted at cycle 6 with its own base, and its beats follow without corruption.
4. Base 0xFFFF_FFF0, unaligned 0x1003, all ready: addresses wrap modulo 2^32 and are 8-byte aligned (0x1003 → 0x1000).
5. `rst_i` asserted in beat 2: all valids are 0 the next cycle, state is IDLE, `result_ready_o`=1, and no `done_o`.
6. Staggered random ready per port across all beats: each of the 32 words is written exactly once with the correct address and data.
